// File: rtl/router_1xn.sv
// router_1xn: one input byte stream routed to NCH output FIFOs with parity check.
// Optional per-channel read-timeout flush is built when ROUTER_RD_TIMEOUT_EN is defined.
module router_1xn #(
    parameter int DW    = 8,
    parameter int NCH   = 3,
    parameter int DEPTH = 16,
    parameter int TMO   = 30
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DW-1:0]     data_in,
    input  logic              pkt_valid,
    output logic              busy,
    output logic              error,
    input  logic [NCH-1:0]    read_enb,
    output logic [NCH-1:0]    vld_out,
    output logic [NCH*DW-1:0] data_out
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] LOAD_DATA    = 3'd1;
    localparam logic [2:0] WAIT_FULL    = 3'd2;
    localparam logic [2:0] LOAD_PARITY  = 3'd3;
    localparam logic [2:0] CHECK_PARITY = 3'd4;
    localparam logic [2:0] DROP         = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [1:0]    cur_addr;
    logic [1:0]    tgt;
    logic [DW-1:0] pend;
    logic [DW-1:0] acc;
    logic [DW-1:0] par_rx;
    logic [DW-1:0] wr_data;

    logic [AW:0]   wptr [NCH];
    logic [AW:0]   rptr [NCH];
    logic [DW-1:0] mem  [NCH][DEPTH];

    logic [NCH-1:0] empty;
    logic [NCH-1:0] full;
    logic [NCH-1:0] rd_fire;
    logic [NCH-1:0] can_wr;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] flush;

    logic tgt_ok;
    logic tgt_can_wr;
    logic tgt_flush;
    logic wr_go;
    logic use_pend;

    // FIFO status; a read in the same cycle frees a slot for a write
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            empty[k]   = (wptr[k] == rptr[k]);
            full[k]    = (wptr[k][AW] != rptr[k][AW]) &&
                         (wptr[k][AW-1:0] == rptr[k][AW-1:0]);
            rd_fire[k] = read_enb[k] && !empty[k];
            can_wr[k]  = !full[k] || rd_fire[k];
        end
    end

    assign vld_out = ~empty;

    // In IDLE the target is the header being offered, later the latched one
    assign tgt = (state == IDLE) ? data_in[1:0] : cur_addr;

    // Select status of the target channel; out-of-range addresses match none
    always_comb begin
        tgt_ok     = 1'b0;
        tgt_can_wr = 1'b0;
        tgt_flush  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (tgt == 2'(k)) begin
                tgt_ok     = 1'b1;
                tgt_can_wr = can_wr[k];
                tgt_flush  = flush[k];
            end
        end
    end

`ifdef ROUTER_RD_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] tcnt [NCH];

    // Flush fires on the TMO-th consecutive unread cycle with data present
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            flush[k] = vld_out[k] && !read_enb[k] &&
                       (tcnt[k] == CW'(TMO - 1));
        end
    end

    // Stall counters restart on any read, on empty and after a flush
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) tcnt[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (!vld_out[k] || read_enb[k] || flush[k])
                    tcnt[k] <= '0;
                else
                    tcnt[k] <= tcnt[k] + 1'b1;
            end
        end
    end
`else
    assign flush = '0;
`endif

    // Packet FSM: accept header/payload, stall when full, then check parity
    always_comb begin
        state_nx = state;
        wr_go    = 1'b0;
        use_pend = 1'b0;
        unique case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (!tgt_ok) begin
                        state_nx = DROP;
                    end else if (tgt_can_wr) begin
                        wr_go    = 1'b1;
                        state_nx = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                if (!pkt_valid)
                    state_nx = LOAD_PARITY;
                else if (tgt_can_wr)
                    wr_go = 1'b1;
                else
                    state_nx = WAIT_FULL;
            end
            WAIT_FULL: begin
                if (tgt_can_wr) begin
                    wr_go    = 1'b1;
                    use_pend = 1'b1;
                    state_nx = LOAD_DATA;
                end
            end
            LOAD_PARITY:  state_nx = CHECK_PARITY;
            CHECK_PARITY: state_nx = IDLE;
            DROP: begin
                if (!pkt_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (tgt_flush && (wr_go || state == LOAD_DATA ||
                          state == WAIT_FULL)) begin
            wr_go    = 1'b0;
            use_pend = 1'b0;
            if (state == LOAD_DATA && !pkt_valid)
                state_nx = IDLE;
            else
                state_nx = DROP;
        end
    end

    // Source must hold its byte while the router cannot take it
    always_comb begin
        busy = 1'b0;
        unique case (state)
            WAIT_FULL, LOAD_PARITY, CHECK_PARITY: busy = 1'b1;
            IDLE:    busy = tgt_ok && !tgt_can_wr;
            default: busy = 1'b0;
        endcase
    end

    assign wr_data = use_pend ? pend : data_in;

    // Per-channel write strobe for the routed byte
    always_comb begin
        for (int k = 0; k < NCH; k++)
            wr_en[k] = wr_go && (tgt == 2'(k));
    end

    // FSM state, running parity, pending byte and error flag
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            acc      <= '0;
            pend     <= '0;
            par_rx   <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && wr_go) begin
                cur_addr <= data_in[1:0];
                acc      <= data_in;
            end
            if (state == LOAD_DATA && pkt_valid) begin
                acc <= acc ^ data_in;
                if (!tgt_can_wr) pend <= data_in;
            end
            if (state == LOAD_DATA && !pkt_valid)
                par_rx <= data_in;
            if (state == CHECK_PARITY)
                error <= (acc != par_rx);
        end
    end

    // FIFO pointers and registered read data
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
            end
            data_out <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (flush[k]) begin
                    wptr[k] <= '0;
                    rptr[k] <= '0;
                end else begin
                    if (wr_en[k])
                        wptr[k] <= wptr[k] + 1'b1;
                    if (rd_fire[k]) begin
                        rptr[k] <= rptr[k] + 1'b1;
                        data_out[k*DW +: DW] <= mem[k][rptr[k][AW-1:0]];
                    end
                end
            end
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clock) begin
        for (int k = 0; k < NCH; k++) begin
            if (wr_en[k])
                mem[k][wptr[k][AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: directed packets with a per-channel byte-stream scoreboard.
module tb_router_1xn;

    localparam int DW    = 8;
    localparam int NCH   = 3;
    localparam int DEPTH = 16;
    localparam int TMO   = 30;

    logic              clock = 1'b0;
    logic              rst;
    logic [DW-1:0]     data_in;
    logic              pkt_valid;
    logic              busy;
    logic              error;
    logic [NCH-1:0]    read_enb;
    logic [NCH-1:0]    vld_out;
    logic [NCH*DW-1:0] data_out;

    int errors = 0;
    int checks = 0;

    logic [7:0]     exp_q [NCH][$];
    logic [7:0]     last  [NCH];
    logic [NCH-1:0] rd_prev = '0;
    int             stall [NCH];

    router_1xn #(
        .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .TMO(TMO)
    ) dut (
        .clock(clock),
        .rst(rst),
        .data_in(data_in),
        .pkt_valid(pkt_valid),
        .busy(busy),
        .error(error),
        .read_enb(read_enb),
        .vld_out(vld_out),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Scoreboard: every pop must deliver the next expected byte,
    // otherwise data_out must hold its previous value.
    initial begin
        for (int k = 0; k < NCH; k++) begin
            last[k]  = '0;
            stall[k] = 0;
        end
        forever begin
            @(negedge clock);
            #2;
            if (!rst) begin
                for (int k = 0; k < NCH; k++) begin
                    exp_q[k].delete();
                    last[k]  = '0;
                    stall[k] = 0;
                end
                rd_prev = '0;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    logic [7:0] got;
                    got = data_out[k*DW +: DW];
                    if (rd_prev[k]) begin
                        if (exp_q[k].size() == 0) begin
                            check($sformatf("pop_extra_ch%0d", k),
                                  32'(exp_q[k].size()), 'h1);
                            last[k] = got;
                        end else begin
                            last[k] = exp_q[k].pop_front();
                            check($sformatf("pop_data_ch%0d", k),
                                  32'(got), 32'(last[k]));
                        end
                    end else begin
                        check($sformatf("hold_ch%0d", k),
                              32'(got), 32'(last[k]));
                    end
`ifdef ROUTER_RD_TIMEOUT_EN
                    if (vld_out[k] && !read_enb[k]) stall[k]++;
                    else stall[k] = 0;
                    if (stall[k] == TMO) begin
                        exp_q[k].delete();
                        stall[k] = 0;
                    end
`endif
                    rd_prev[k] = read_enb[k] && vld_out[k];
                end
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b, input logic v);
        int n;
        @(negedge clock);
        data_in   = b;
        pkt_valid = v;
        #1;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 200) check("busy_bound", 32'(busy), 'h0);
    endtask

    task automatic send_pkt(input int a, input int len,
                            input logic [7:0] base, input logic [7:0] step,
                            input bit corrupt);
        logic [7:0] hdr;
        logic [7:0] b;
        logic [7:0] par;
        hdr = 8'(len << 2) | 8'(a);
        par = hdr;
        if (a < NCH) exp_q[a].push_back(hdr);
        drive_byte(hdr, 1'b1);
        for (int i = 0; i < len; i++) begin
            b   = base + 8'(i) * step;
            par = par ^ b;
            if (a < NCH) exp_q[a].push_back(b);
            drive_byte(b, 1'b1);
        end
        if (corrupt) par = ~par;
        drive_byte(par, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            pkt_valid = 1'b0;
        end
    endtask

    task automatic rd(input logic [NCH-1:0] mask, input int n);
        @(negedge clock);
        read_enb = mask;
        repeat (n) @(negedge clock);
        read_enb = '0;
    endtask

    initial begin
        rst       = 1'b0;
        data_in   = '0;
        pkt_valid = 1'b0;
        read_enb  = '0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", 32'(busy), 'h0);
        check("rst_error", 32'(error), 'h0);
        check("rst_vld", 32'(vld_out), 'h0);
        check("rst_data", 32'(data_out), 'h0);
        @(negedge clock);
        rst = 1'b1;
        idle(2);

        send_pkt(1, 3, 8'h11, 8'h11, 1'b0);
        idle(4);
        #1;
        check("basic_vld", 32'(vld_out), 'h2);
        check("basic_error", 32'(error), 'h0);
        rd(3'b010, 4);
        idle(2);
        #1;
        check("basic_last", 32'(data_out[15:8]), 'h33);
        check("basic_vld_drained", 32'(vld_out), 'h0);

        send_pkt(1, 3, 8'h11, 8'h11, 1'b1);
        idle(4);
        #1;
        check("bad_par_error", 32'(error), 'h1);
        check("bad_par_vld", 32'(vld_out), 'h2);
        rd(3'b010, 4);
        idle(2);
        #1;
        check("bad_par_drained", 32'(vld_out), 'h0);

        send_pkt(3, 1, 8'h77, 8'h01, 1'b0);
        idle(4);
        #1;
        check("drop_vld", 32'(vld_out), 'h0);
        check("drop_error_kept", 32'(error), 'h1);

        @(negedge clock);
        data_in   = 8'h16;
        pkt_valid = 1'b1;
        @(negedge clock);
        data_in = 8'hA1;
        @(negedge clock);
        data_in = 8'hA2;
        #1;
        check("mid_pkt_vld", 32'(vld_out), 'h4);
        rst       = 1'b0;
        pkt_valid = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 'h0);
        check("mid_rst_error", 32'(error), 'h0);
        check("mid_rst_vld", 32'(vld_out), 'h0);
        check("mid_rst_data", 32'(data_out), 'h0);
        idle(2);
        @(negedge clock);
        rst = 1'b1;

        send_pkt(2, 0, 8'h00, 8'h00, 1'b0);
        idle(4);
        #1;
        check("l0_vld", 32'(vld_out), 'h4);
        check("l0_error", 32'(error), 'h0);
        rd(3'b100, 1);
        idle(2);
        #1;
        check("l0_data", 32'(data_out[23:16]), 'h02);
        check("l0_drained", 32'(vld_out), 'h0);

        fork
            send_pkt(0, 20, 8'h40, 8'h01, 1'b0);
            begin
                repeat (25) @(negedge clock);
                #1;
                check("full_busy", 32'(busy), 'h1);
                check("full_vld", 32'(vld_out), 'h1);
                read_enb = 3'b001;
            end
        join
        repeat (30) @(negedge clock);
        read_enb = '0;
        #1;
        check("full_all_read", 32'(exp_q[0].size()), 'h0);
        check("full_drained", 32'(vld_out), 'h0);
        check("full_last", 32'(data_out[7:0]), 'h53);
        check("full_error", 32'(error), 'h0);

`ifdef ROUTER_RD_TIMEOUT_EN
        fork
            send_pkt(2, 1, 8'h5A, 8'h00, 1'b0);
            begin
                int n;
                int hi;
                n  = 0;
                hi = 0;
                while (!vld_out[2] && n < 100) begin
                    @(negedge clock);
                    #1;
                    n++;
                end
                while (vld_out[2] && hi < 200) begin
                    @(negedge clock);
                    #1;
                    hi++;
                end
                check("tmo_cycles", 32'(hi), 32'(TMO));
            end
        join
        idle(2);
        #1;
        check("tmo_vld", 32'(vld_out), 'h0);
        check("tmo_model_empty", 32'(exp_q[2].size()), 'h0);
`else
        send_pkt(2, 1, 8'h5A, 8'h00, 1'b0);
        repeat (60) @(negedge clock);
        #1;
        check("persist_vld", 32'(vld_out), 'h4);
        rd(3'b100, 2);
        idle(2);
        #1;
        check("persist_drained", 32'(vld_out), 'h0);
        check("persist_data", 32'(data_out[23:16]), 'h5A);
`endif

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_1xn.md
ROUTER_1XN -- requirements
Module: router_1xn

Interface
REQ-001 SHALL have parameter DW, default 8: data byte width; legal 8..16.
REQ-002 SHALL have parameter NCH, default 3: output channel count; legal 2..4.
REQ-003 SHALL have parameter DEPTH, default 16: per-channel FIFO entries; power of 2, legal 4..64.
REQ-004 SHALL have parameter TMO, default 30: read-timeout cycle count.
REQ-005 clock  in  1  sole clock; all state on posedge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 data_in  in  DW  header, payload or parity byte.
REQ-008 pkt_valid  in  1  high for header and payload; low on the parity byte.
REQ-009 busy  out  1  source holds data_in/pkt_valid while high.
REQ-010 error  out  1  parity mismatch on last packet.
REQ-011 read_enb  in  NCH  per-channel pop request.
REQ-012 vld_out  out  NCH  per-channel FIFO non-empty.
REQ-013 data_out  out  NCH*DW  channel k occupies bits [k*DW +: DW].

Function
REQ-014 Header: addr = data_in[1:0], payload length L = data_in[DW-1:2]; L=0 legal (header then parity only).
REQ-015 FSM states: IDLE, LOAD_DATA, WAIT_FULL, LOAD_PARITY, CHECK_PARITY, DROP.
REQ-016 IDLE->LOAD_DATA when pkt_valid=1 and addr<NCH; header written to FIFO[addr] that cycle.
REQ-017 IDLE->DROP when pkt_valid=1 and addr>=NCH; no FIFO write, error unchanged.
REQ-018 LOAD_DATA: each cycle with pkt_valid=1 writes data_in to FIFO[addr]; ->WAIT_FULL if write would overflow; ->LOAD_PARITY on pkt_valid=0.
REQ-019 WAIT_FULL: no write; busy=1; ->LOAD_DATA when FIFO[addr] has a free entry; pending byte written on exit cycle.
REQ-020 LOAD_PARITY: latch data_in as received parity; not written to FIFO; ->CHECK_PARITY.
REQ-021 CHECK_PARITY: compare XOR of header and all payload bytes with received parity; error<=1 on mismatch, 0 on match; ->IDLE.
REQ-022 DROP: discard bytes until pkt_valid=0, consume parity cycle, ->IDLE.
REQ-023 busy=1 in WAIT_FULL, LOAD_PARITY, CHECK_PARITY; also in IDLE when FIFO[addr of data_in] is full; 0 otherwise.
REQ-024 error holds until next CHECK_PARITY.
REQ-025 Read: read_enb[k]=1 with vld_out[k]=1 in cycle N -> byte on data_out[k] in cycle N+1; data_out holds otherwise.
REQ-026 read_enb[k]=1 with FIFO empty: no pointer change, data_out unchanged.
REQ-027 Simultaneous write and read on one FIFO SHALL succeed when full (read frees entry same cycle) and when empty (vld_out rises next cycle).
REQ-028 Pointers SHALL be log2(DEPTH)+1 bits; full/empty by MSB compare, wrap-around without loss.
REQ-029 Channels read independently; a stalled channel SHALL not block reads on others.

Reset
REQ-030 rst=0 SHALL immediately clear FSM to IDLE, all pointers, busy=0, error=0, vld_out=0, data_out=0, timeout counters=0.
REQ-031 Reset mid-packet SHALL discard the partial packet; first pkt_valid after release is treated as a header.

Configuration
REQ-032 Macro ROUTER_RD_TIMEOUT_EN: when defined, a channel with vld_out=1 and read_enb=0 for TMO consecutive cycles SHALL soft-reset that FIFO only (empty next cycle); counter restarts on any read.
REQ-033 Without ROUTER_RD_TIMEOUT_EN, FIFO contents SHALL persist indefinitely and no counter logic is present.
REQ-034 Soft reset on the channel being written SHALL also drop the in-flight packet, FSM->DROP.

Verification
REQ-035 NCH=3: header 8'h0D (addr1, L=3), payload 11,22,33, parity 8'h0D^11^22^33 -> vld_out=3'b010, 4 bytes read in order, error=0.
REQ-036 Same packet, parity byte inverted -> error=1 after CHECK_PARITY, bytes still delivered.
REQ-037 DEPTH=16, addr0, L=20, no reads -> busy=1 after 16 writes; start reads -> all 21 bytes delivered, none lost.
REQ-038 Header 8'h07 (addr3, NCH=3) -> no vld_out change, error unchanged, next valid packet routed normally.
REQ-039 With ROUTER_RD_TIMEOUT_EN, TMO=30: packet to ch2, no reads -> vld_out[2] falls at cycle 30; without macro stays high.
REQ-040 rst=0 during LOAD_DATA -> all outputs 0 same cycle; subsequent packet received intact.
